// File: rtl/cdb_pkg.sv
// Shared widths, execution-unit indices and the broadcast record for the
// common data bus.
package cdb_pkg;

  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    U_INT   = 2'd0,
    U_LD_SW = 2'd1,
    U_MULT  = 2'd2,
    U_DIV   = 2'd3
  } unit_e;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic              branch;
    logic              branch_taken;
  } cdb_bus_t;

endpackage

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin grant: the first requester at or after ptr wins.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter_4
  import cdb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid
);

  always_comb begin
    gnt       = '0;
    gnt_idx   = ptr;
    gnt_valid = 1'b0;
    // ptr + i wraps naturally in 2 bits, giving the modulo-4 search order
    for (int i = 0; i < 4; i++) begin
      if (!gnt_valid && req[ptr + 2'(i)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = ptr + 2'(i);
      end
    end
    if (gnt_valid) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB producer: round-robin pick among the four tag-buffer heads, pop the winner
// and register its result onto the broadcast bus one cycle later.
module cdb_arbiter #(
  parameter int TAG_W  = cdb_pkg::TAG_W,
  parameter int DATA_W = cdb_pkg::DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              int_valid,
  input  logic [TAG_W-1:0]  int_tag,
  input  logic [DATA_W-1:0] int_data,
  input  logic              int_branch,
  input  logic              int_branch_taken,
  input  logic              ld_sw_valid,
  input  logic [TAG_W-1:0]  ld_sw_tag,
  input  logic [DATA_W-1:0] ld_sw_data,
  input  logic              mult_valid,
  input  logic [TAG_W-1:0]  mult_tag,
  input  logic [DATA_W-1:0] mult_data,
  input  logic              div_valid,
  input  logic [TAG_W-1:0]  div_tag,
  input  logic [DATA_W-1:0] div_data,
  output logic              tb_int_rd,
  output logic              tb_ld_sw_rd,
  output logic              tb_mult_rd,
  output logic              tb_div_rd,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  output logic              cdb_branch,
  output logic              cdb_branch_taken
);
  import cdb_pkg::*;

  logic [3:0]        req;
  logic [3:0]        gnt;
  logic [1:0]        gnt_idx;
  logic              gnt_valid;
  logic              grant_en;
  logic [1:0]        ptr;

  logic              nxt_valid;
  logic [TAG_W-1:0]  nxt_tag;
  logic [DATA_W-1:0] nxt_data;
  logic              nxt_branch;
  logic              nxt_taken;

  assign req = {div_valid, mult_valid, ld_sw_valid, int_valid};

  rr_arbiter_4 u_rr (
    .req       (req),
    .ptr       (ptr),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // Reset also blocks pops so nothing leaves a tag buffer while held in reset
  assign grant_en    = gnt_valid & ~i_flush & ~i_rst;
  assign tb_int_rd   = grant_en & gnt[U_INT];
  assign tb_ld_sw_rd = grant_en & gnt[U_LD_SW];
  assign tb_mult_rd  = grant_en & gnt[U_MULT];
  assign tb_div_rd   = grant_en & gnt[U_DIV];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)         ptr <= 2'd0;
    else if (grant_en) ptr <= gnt_idx + 2'd1;
  end

  always_comb begin
    nxt_valid  = 1'b0;
    nxt_tag    = '0;
    nxt_data   = '0;
    nxt_branch = 1'b0;
    nxt_taken  = 1'b0;
    if (grant_en) begin
      nxt_valid = 1'b1;
      case (unit_e'(gnt_idx))
        U_INT: begin
          nxt_tag    = int_tag;
          nxt_data   = int_data;
          nxt_branch = int_branch;
          nxt_taken  = int_branch & int_branch_taken;
        end
        U_LD_SW: begin
          nxt_tag  = ld_sw_tag;
          nxt_data = ld_sw_data;
        end
        U_MULT: begin
          nxt_tag  = mult_tag;
          nxt_data = mult_data;
        end
        default: begin
          nxt_tag  = div_tag;
          nxt_data = div_data;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cdb_valid        <= 1'b0;
      cdb_tag          <= '0;
      cdb_data         <= '0;
      cdb_branch       <= 1'b0;
      cdb_branch_taken <= 1'b0;
    end else begin
      cdb_valid        <= nxt_valid;
      cdb_tag          <= nxt_tag;
      cdb_data         <= nxt_data;
      cdb_branch       <= nxt_branch;
      cdb_branch_taken <= nxt_taken;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a negedge scoreboard predicts pops and the
// following-cycle broadcast; the initial block adds scenario-specific checks.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              int_valid = 1'b0, int_branch = 1'b0, int_taken = 1'b0;
  logic [TAG_W-1:0]  int_tag = '0, ld_sw_tag = '0, mult_tag = '0, div_tag = '0;
  logic [DATA_W-1:0] int_data = '0, ld_sw_data = '0, mult_data = '0, div_data = '0;
  logic              ld_sw_valid = 1'b0, mult_valid = 1'b0, div_valid = 1'b0;
  logic              tb_int_rd, tb_ld_sw_rd, tb_mult_rd, tb_div_rd;
  logic              cdb_valid, cdb_branch, cdb_branch_taken;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;

  int n_assert = 0;
  int n_fail   = 0;

  cdb_bus_t         exp_q[$];
  logic [TAG_W-1:0] seen_tags[$];
  int               m_ptr = 0;

  always #5 clk = ~clk;

  cdb_arbiter dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .int_valid(int_valid), .int_tag(int_tag), .int_data(int_data),
    .int_branch(int_branch), .int_branch_taken(int_taken),
    .ld_sw_valid(ld_sw_valid), .ld_sw_tag(ld_sw_tag), .ld_sw_data(ld_sw_data),
    .mult_valid(mult_valid), .mult_tag(mult_tag), .mult_data(mult_data),
    .div_valid(div_valid), .div_tag(div_tag), .div_data(div_data),
    .tb_int_rd(tb_int_rd), .tb_ld_sw_rd(tb_ld_sw_rd),
    .tb_mult_rd(tb_mult_rd), .tb_div_rd(tb_div_rd),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_branch(cdb_branch), .cdb_branch_taken(cdb_branch_taken)
  );

  // Scoreboard: compare the broadcast predicted last cycle, then predict this cycle's pop
  always @(negedge clk) begin
    cdb_bus_t   obs, exp_bus, nxt;
    logic [3:0] rd, req, exp_rd;
    int         win, k;
    obs = {cdb_valid, cdb_tag, cdb_data, cdb_branch, cdb_branch_taken};
    rd  = {tb_div_rd, tb_mult_rd, tb_ld_sw_rd, tb_int_rd};
    if (rst) begin
      n_assert++;
      assert (obs === '0 && rd === 4'b0000) else begin
        n_fail++;
        $error("FAIL reset_state: cdb=%h rd=%b expected cdb=0 rd=0000", obs, rd);
      end
      exp_q.delete();
      exp_q.push_back('0);
      m_ptr = 0;
    end else begin
      if (exp_q.size() > 0) begin
        exp_bus = exp_q.pop_front();
        n_assert++;
        assert (obs === exp_bus) else begin
          n_fail++;
          $error("FAIL cdb_bus: observed=%h expected=%h", obs, exp_bus);
        end
        if (obs.valid) seen_tags.push_back(obs.tag);
      end
      req    = {div_valid, mult_valid, ld_sw_valid, int_valid};
      exp_rd = 4'b0000;
      win    = -1;
      if (!flush) begin
        for (int i = 0; i < 4; i++) begin
          k = (m_ptr + i) % 4;
          if (win < 0 && req[k]) win = k;
        end
      end
      if (win >= 0) exp_rd[win] = 1'b1;
      n_assert++;
      assert (rd === exp_rd) else begin
        n_fail++;
        $error("FAIL tb_rd: observed=%b expected=%b ptr=%0d", rd, exp_rd, m_ptr);
      end
      nxt = '0;
      case (win)
        0: nxt = {1'b1, int_tag, int_data, int_branch, int_branch & int_taken};
        1: nxt = {1'b1, ld_sw_tag, ld_sw_data, 1'b0, 1'b0};
        2: nxt = {1'b1, mult_tag, mult_data, 1'b0, 1'b0};
        3: nxt = {1'b1, div_tag, div_data, 1'b0, 1'b0};
        default: nxt = '0;
      endcase
      exp_q.push_back(nxt);
      if (win >= 0) m_ptr = (win + 1) % 4;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [TAG_W-1:0] exp3 [8];
    logic [TAG_W-1:0] exp46 [4];
    exp3  = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h01, 6'h02, 6'h03, 6'h04};
    exp46 = '{6'h21, 6'h30, 6'h07, 6'h31};

    repeat (2) step();
    rst = 1'b0;

    // 1: reset mid-stream with INT continuously valid
    int_valid = 1'b1; int_tag = 6'h11; int_data = 32'h0000_1111;
    repeat (3) step();
    rst = 1'b1;
    #1;
    n_assert++;
    assert (cdb_valid === 1'b0 && tb_int_rd === 1'b0) else begin
      n_fail++;
      $error("FAIL async_reset: cdb_valid=%b tb_int_rd=%b expected 0/0", cdb_valid, tb_int_rd);
    end
    repeat (2) step();
    rst = 1'b0;
    at_neg();
    n_assert++;
    assert (tb_int_rd === 1'b1 && cdb_valid === 1'b0) else begin
      n_fail++;
      $error("FAIL post_reset_pop: rd=%b valid=%b expected 1/0", tb_int_rd, cdb_valid);
    end
    step();
    int_valid = 1'b0;
    at_neg();
    n_assert++;
    assert (cdb_valid === 1'b1 && cdb_tag === 6'h11) else begin
      n_fail++;
      $error("FAIL post_reset_bcast: valid=%b tag=%h expected 1/11", cdb_valid, cdb_tag);
    end
    repeat (2) step();

    // 2: single INT branch resolution
    int_valid = 1'b1; int_tag = 6'h05; int_data = 32'hDEAD_BEEF;
    int_branch = 1'b1; int_taken = 1'b1;
    at_neg();
    n_assert++;
    assert (tb_int_rd === 1'b1) else begin
      n_fail++;
      $error("FAIL int_branch_pop: tb_int_rd=%b expected 1", tb_int_rd);
    end
    step();
    int_valid = 1'b0; int_branch = 1'b0; int_taken = 1'b0;
    at_neg();
    n_assert++;
    assert ({cdb_valid, cdb_tag, cdb_data, cdb_branch, cdb_branch_taken} ===
            {1'b1, 6'h05, 32'hDEAD_BEEF, 1'b1, 1'b1}) else begin
      n_fail++;
      $error("FAIL int_branch_bcast: got %b %h %h %b %b expected 1 05 deadbeef 1 1",
             cdb_valid, cdb_tag, cdb_data, cdb_branch, cdb_branch_taken);
    end
    step();
    at_neg();
    n_assert++;
    assert (cdb_valid === 1'b0 && cdb_tag === '0 && cdb_data === '0) else begin
      n_fail++;
      $error("FAIL idle_clear: valid=%b tag=%h data=%h expected all 0", cdb_valid, cdb_tag, cdb_data);
    end

    // Re-reset so the pointer starts at INT for the fairness sequence
    step();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();

    // 3: all four valid for eight cycles
    seen_tags.delete();
    int_valid = 1'b1;   int_tag = 6'h01;   int_data = 32'h101;
    ld_sw_valid = 1'b1; ld_sw_tag = 6'h02; ld_sw_data = 32'h102;
    mult_valid = 1'b1;  mult_tag = 6'h03;  mult_data = 32'h103;
    div_valid = 1'b1;   div_tag = 6'h04;   div_data = 32'h104;
    repeat (8) step();
    int_valid = 1'b0; ld_sw_valid = 1'b0; mult_valid = 1'b0; div_valid = 1'b0;
    at_neg();
    step();
    n_assert++;
    assert (seen_tags.size() == 8) else begin
      n_fail++;
      $error("FAIL rr_count: observed=%0d broadcasts expected=8", seen_tags.size());
    end
    for (int i = 0; i < 8 && i < seen_tags.size(); i++) begin
      n_assert++;
      assert (seen_tags[i] === exp3[i]) else begin
        n_fail++;
        $error("FAIL rr_order[%0d]: observed=%h expected=%h", i, seen_tags[i], exp3[i]);
      end
    end

    // 4 and 6: MULT+DIV with pointer at INT, then wrap back to INT
    seen_tags.delete();
    mult_valid = 1'b1; mult_tag = 6'h21; mult_data = 32'h2121;
    div_valid  = 1'b1; div_tag  = 6'h30; div_data  = 32'h3030;
    int_branch = 1'b1; int_taken = 1'b1;
    at_neg();
    n_assert++;
    assert (tb_mult_rd === 1'b1 && tb_div_rd === 1'b0) else begin
      n_fail++;
      $error("FAIL mult_first: mult_rd=%b div_rd=%b expected 1/0", tb_mult_rd, tb_div_rd);
    end
    step();
    mult_valid = 1'b0; int_branch = 1'b0;
    at_neg();
    n_assert++;
    assert (cdb_tag === 6'h21 && cdb_branch === 1'b0 && cdb_branch_taken === 1'b0) else begin
      n_fail++;
      $error("FAIL mult_bcast: tag=%h branch=%b taken=%b expected 21/0/0", cdb_tag, cdb_branch, cdb_branch_taken);
    end
    step();
    div_tag = 6'h31; div_data = 32'h3131;
    int_valid = 1'b1; int_tag = 6'h07; int_data = 32'h0707; int_branch = 1'b1; int_taken = 1'b0;
    at_neg();
    n_assert++;
    assert (tb_int_rd === 1'b1 && tb_div_rd === 1'b0) else begin
      n_fail++;
      $error("FAIL wrap_int_wins: int_rd=%b div_rd=%b expected 1/0", tb_int_rd, tb_div_rd);
    end
    n_assert++;
    assert (cdb_tag === 6'h30 && cdb_branch === 1'b0) else begin
      n_fail++;
      $error("FAIL div_bcast: tag=%h branch=%b expected 30/0", cdb_tag, cdb_branch);
    end
    step();
    int_valid = 1'b0; int_branch = 1'b0;
    step();
    div_valid = 1'b0;
    step();
    at_neg();
    n_assert++;
    assert (seen_tags.size() == 4) else begin
      n_fail++;
      $error("FAIL wrap_count: observed=%0d broadcasts expected=4", seen_tags.size());
    end
    for (int i = 0; i < 4 && i < seen_tags.size(); i++) begin
      n_assert++;
      assert (seen_tags[i] === exp46[i]) else begin
        n_fail++;
        $error("FAIL wrap_order[%0d]: observed=%h expected=%h", i, seen_tags[i], exp46[i]);
      end
    end

    // 5: flush holds off an LD/SW pop until released
    step();
    ld_sw_valid = 1'b1; ld_sw_tag = 6'h0A; ld_sw_data = 32'h0A0A_0A0A; flush = 1'b1;
    at_neg();
    n_assert++;
    assert (tb_ld_sw_rd === 1'b0) else begin
      n_fail++;
      $error("FAIL flush_no_pop: tb_ld_sw_rd=%b expected 0", tb_ld_sw_rd);
    end
    step();
    at_neg();
    n_assert++;
    assert (cdb_valid === 1'b0) else begin
      n_fail++;
      $error("FAIL flush_no_bcast: cdb_valid=%b expected 0", cdb_valid);
    end
    step();
    flush = 1'b0;
    at_neg();
    n_assert++;
    assert (tb_ld_sw_rd === 1'b1) else begin
      n_fail++;
      $error("FAIL unflush_pop: tb_ld_sw_rd=%b expected 1", tb_ld_sw_rd);
    end
    step();
    ld_sw_valid = 1'b0;
    at_neg();
    n_assert++;
    assert (cdb_valid === 1'b1 && cdb_tag === 6'h0A && cdb_data === 32'h0A0A_0A0A) else begin
      n_fail++;
      $error("FAIL unflush_bcast: valid=%b tag=%h data=%h expected 1/0a/0a0a0a0a", cdb_valid, cdb_tag, cdb_data);
    end
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
